// File: rtl/snorm_auto.sv
// Iterative signed auto-normalizer: finds the left shift that removes redundant sign bits,
// one shift per clock, and returns the truncated mantissa f with the shift count e.
module snorm_auto #(
  parameter int A_WIDTH = 32,
  parameter int F_WIDTH = 16,
  parameter int E_WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [A_WIDTH-1:0] a,
  input  logic               a_valid,
  output logic               a_ready,
  output logic [F_WIDTH-1:0] f,
  output logic [E_WIDTH-1:0] e,
  output logic               f_valid,
  input  logic               f_ready
);

  generate
    if (F_WIDTH > A_WIDTH) begin : g_bad_fwidth
      $error("snorm_auto: F_WIDTH must not exceed A_WIDTH");
    end
    if ((2 ** E_WIDTH) <= (A_WIDTH - 1)) begin : g_bad_ewidth
      $error("snorm_auto: E_WIDTH too small to hold A_WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] sr;
  logic [E_WIDTH-1:0] cnt;
  logic               norm_done;

  // Normalized once the top two bits differ, or the count cap is hit (a = 0 or -1).
  assign norm_done = (sr[A_WIDTH-1] != sr[A_WIDTH-2]) || (cnt == E_WIDTH'(A_WIDTH - 1));

  assign a_ready = (state == IDLE) && !reset;
  assign f_valid = (state == DONE) && !reset;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (a_valid) state_nxt = SHIFT;
      SHIFT:   if (norm_done) state_nxt = DONE;
      DONE:    if (f_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      f     <= '0;
      e     <= '0;
    end else begin
      state <= state_nxt;
      if (state == SHIFT && norm_done) begin
        f <= sr[A_WIDTH-1 -: F_WIDTH];
        e <= cnt;
      end
    end
  end

  // NOTE: the working registers carry no reset; they are always loaded in IDLE before use.
  always_ff @(posedge clk) begin
    if (state == IDLE && a_valid) begin
      sr  <= a;
      cnt <= '0;
    end else if (state == SHIFT && !norm_done) begin
      sr  <= sr << 1;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_snorm_auto.sv
// Directed and lightly randomized bench for snorm_auto at the default 32/16/6 configuration.
module tb_snorm_auto;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic        a_valid;
  logic        a_ready;
  logic [15:0] f;
  logic [5:0]  e;
  logic        f_valid;
  logic        f_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  snorm_auto #(.A_WIDTH(32), .F_WIDTH(16), .E_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .f(f), .e(e), .f_valid(f_valid), .f_ready(f_ready)
  );

  typedef struct {
    logic [31:0] a;
    int          exp_e;
    logic [15:0] exp_f;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference leading-redundant-sign-bit count.
  function automatic int ref_e(input logic [31:0] v);
    int n = 0;
    for (int j = 30; j >= 0; j--) begin
      if (v[j] != v[31]) break;
      n++;
    end
    return n;
  endfunction

  // Present one value and wait for f_valid; lat counts cycles from the accept cycle.
  task automatic run_txn(input logic [31:0] val, output int lat, output logic ok);
    a = val;
    a_valid = 1'b1;
    check("a_ready_idle", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    lat = 1;
    while (!f_valid && lat < 100) begin
      tick();
      lat++;
    end
    ok = f_valid;
    if (!ok) check("f_valid_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[9];
  int   lat;
  logic ok;
  logic [15:0] held_f;
  logic [5:0]  held_e;
  int   highs;

  initial begin
    vecs[0] = '{32'h0000_1000, 18, 16'h4000, 20};
    vecs[1] = '{32'h8000_0000, 0,  16'h8000, 2};
    vecs[2] = '{32'h4000_0000, 0,  16'h4000, 2};
    vecs[3] = '{32'hFFFF_F000, 19, 16'h8000, 21};
    vecs[4] = '{32'h0000_0000, 31, 16'h0000, 33};
    vecs[5] = '{32'hFFFF_FFFF, 31, 16'h8000, 33};
    vecs[6] = '{32'h0000_0001, 30, 16'h4000, 32};
    vecs[7] = '{32'hC000_0000, 1,  16'h8000, 3};
    vecs[8] = '{32'h1234_5678, 2,  16'h48D1, 4};

    reset = 1'b1; a = '0; a_valid = 1'b1; f_ready = 1'b1;
    tick();
    tick();
    check("rst_a_ready", {31'd0, a_ready}, 32'd0);
    check("rst_f_valid", {31'd0, f_valid}, 32'd0);
    check("rst_f", {16'd0, f}, 32'd0);
    check("rst_e", {26'd0, e}, 32'd0);
    reset = 1'b0;
    a_valid = 1'b0;
    #1;
    check("post_rst_a_ready", {31'd0, a_ready}, 32'd1);

    foreach (vecs[i]) begin
      run_txn(vecs[i].a, lat, ok);
      if (ok) begin
        check($sformatf("v%0d_e", i), {26'd0, e}, 32'(vecs[i].exp_e));
        check($sformatf("v%0d_f", i), {16'd0, f}, {16'd0, vecs[i].exp_f});
        check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        check($sformatf("v%0d_busy", i), {31'd0, a_ready}, 32'd0);
        held_f = f;
        tick();
        check($sformatf("v%0d_ready_back", i), {31'd0, a_ready}, 32'd1);
        check($sformatf("v%0d_fv_low", i), {31'd0, f_valid}, 32'd0);
        check($sformatf("v%0d_f_hold", i), {16'd0, f}, {16'd0, held_f});
      end
    end

    // Backpressure in DONE: outputs frozen, new input ignored.
    f_ready = 1'b0;
    run_txn(32'h0000_1000, lat, ok);
    held_f = f;
    held_e = e;
    for (int c = 0; c < 10; c++) begin
      a = 32'h0000_00FF;
      a_valid = c[0];
      tick();
      check("bp_f_valid", {31'd0, f_valid}, 32'd1);
      check("bp_a_ready", {31'd0, a_ready}, 32'd0);
      check("bp_f", {16'd0, f}, 32'h4000);
      check("bp_e", {26'd0, e}, 32'd18);
    end
    a_valid = 1'b0;
    f_ready = 1'b1;
    tick();
    check("bp_ready_back", {31'd0, a_ready}, 32'd1);
    check("bp_fv_low", {31'd0, f_valid}, 32'd0);
    check("bp_f_after", {16'd0, f}, {16'd0, held_f});
    check("bp_e_after", {26'd0, e}, {26'd0, held_e});

    // Reset mid-SHIFT aborts the in-flight result.
    a = 32'h0000_0001;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_idle", {31'd0, a_ready}, 32'd1);
    highs = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (f_valid) highs++;
    end
    check("mid_rst_no_result", 32'(highs), 32'd0);
    run_txn(32'h0000_00FF, lat, ok);
    check("ff_e", {26'd0, e}, 32'd23);
    check("ff_f", {16'd0, f}, 32'h7F80);
    check("ff_lat", 32'(lat), 32'd25);
    tick();

    // Reset while in DONE clears f/e and drops f_valid.
    f_ready = 1'b0;
    run_txn(32'h8000_0000, lat, ok);
    reset = 1'b1;
    #1;
    check("done_rst_fv", {31'd0, f_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("done_rst_fv_after", {31'd0, f_valid}, 32'd0);
    check("done_rst_f", {16'd0, f}, 32'd0);
    check("done_rst_ready", {31'd0, a_ready}, 32'd1);
    f_ready = 1'b1;

    // Random values with random stalls on both sides.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] rv;
      logic [31:0] shifted;
      int          exp_e;
      int          wait_cyc;
      rv = $urandom;
      rv = 32'($signed(rv) >>> $urandom_range(0, 31));
      exp_e = ref_e(rv);
      shifted = rv << exp_e;
      for (int s = $urandom_range(0, 2); s > 0; s--) tick();
      a = rv;
      a_valid = 1'b1;
      wait_cyc = 0;
      while (!a_ready && wait_cyc < 100) begin
        tick();
        wait_cyc++;
      end
      tick();
      a_valid = 1'b0;
      wait_cyc = 0;
      f_ready = 1'($urandom_range(0, 1));
      while (!(f_valid && f_ready) && wait_cyc < 100) begin
        tick();
        f_ready = 1'($urandom_range(0, 1));
        wait_cyc++;
      end
      if (wait_cyc >= 100) begin
        check("rnd_timeout", 32'd0, 32'd1);
      end else begin
        check("rnd_e", {26'd0, e}, 32'(exp_e));
        check("rnd_f", {16'd0, f}, {16'd0, shifted[31:16]});
      end
      tick();
      f_ready = 1'b1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
